contador_carga: RTL and testbench

//  Loadable W-bit counter with enable. Driven by clk/e/reset/data stimulus from the lab benches.

---
 rtl/contador_pkg.sv | 28 ++
 rtl/tc_detect.sv | 17 +
 rtl/contador_carga.sv | 97 +++++++++
 tb/tb_contador_carga.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/contador_pkg.sv
// Shared types and helpers for the loadable counter: FSM state encoding, default width and the
// next-count function used by the counter datapath.
package contador_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StDone = 2'b10
  } state_e;

  // Next count for an enabled edge; terminal value is maxv going up, 0 going down.
  function automatic logic [31:0] next_val(input logic [31:0] q, input logic up,
                                           input logic [31:0] maxv, input logic wrap);
    logic [31:0] r;
    r = q;
    if (up) begin
      if (q == maxv) r = wrap ? 32'd0 : maxv;
      else           r = q + 32'd1;
    end else begin
      if (q == 32'd0) r = wrap ? maxv : 32'd0;
      else            r = q - 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tc_detect.sv
// Terminal-count compare: flags q at MAXV when counting up, or at 0 when counting down.
module tc_detect #(
  parameter int unsigned W    = 4,
  parameter int unsigned MAXV = (1 << W) - 1
) (
  input  logic [W-1:0] q_i,
  input  logic         up_i,
  output logic         at_term_o
);

  localparam logic [W-1:0] MaxQ = W'(MAXV);

  always_comb begin
    at_term_o = up_i ? (q_i == MaxQ) : (q_i == '0);
  end

endmodule

// File: rtl/contador_carga.sv
// Loadable W-bit counter with enable, terminal-count pulse and IDLE/RUN/DONE tracking.
// Define CONTADOR_UPDOWN_EN to add the "up_i" direction input (down-counting terminates at 0).
module contador_carga
  import contador_pkg::*;
#(
  parameter int unsigned W    = CNT_W,
  parameter bit          WRAP = 1'b1,
  parameter int unsigned MAXV = (1 << W) - 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         e_i,
  input  logic         load_i,
  input  logic [W-1:0] data_i,
`ifdef CONTADOR_UPDOWN_EN
  input  logic         up_i,
`endif
  output logic [W-1:0] q_o,
  output logic         tc_o,
  output logic         busy_o,
  output logic         done_o
);

  localparam logic [W-1:0] MaxQ = W'(MAXV);

  state_e       state_q, state_d;
  logic [W-1:0] q_q, q_d;
  logic         tc_q, tc_d;
  logic         dir;
  logic         at_term;

`ifdef CONTADOR_UPDOWN_EN
  assign dir = up_i;
`else
  assign dir = 1'b1;
`endif

  tc_detect #(
    .W    (W),
    .MAXV (MAXV)
  ) u_tc_detect (
    .q_i       (q_q),
    .up_i      (dir),
    .at_term_o (at_term)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    tc_d    = 1'b0;
    if (load_i) begin
      // Loads above the terminal value are clamped so q never exceeds MAXV.
      q_d     = (data_i > MaxQ) ? MaxQ : data_i;
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle, StRun: begin
          if (e_i) begin
            q_d = W'(next_val(32'(q_q), dir, MAXV, WRAP));
            if (at_term) begin
              tc_d    = 1'b1;
              state_d = WRAP ? StRun : StDone;
            end else begin
              state_d = StRun;
            end
          end else begin
            state_d = StIdle;
          end
        end
        StDone: begin
          state_d = StDone;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      q_q     <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      tc_q    <= tc_d;
    end
  end

  assign q_o    = q_q;
  assign tc_o   = tc_q;
  assign busy_o = (state_q == StRun);
  assign done_o = (state_q == StDone);

endmodule

// File: tb/tb_contador_carga.sv
// Self-checking bench: three counter instances (wrapping, stopping, W=5/MAXV=12) share stimulus.
module tb_contador_carga;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       e;
  logic       load;
  logic [4:0] data;
`ifdef CONTADOR_UPDOWN_EN
  logic       up;
`endif

  logic [3:0] q_w, q_s;
  logic [4:0] q_m;
  logic       tc_w, busy_w, done_w;
  logic       tc_s, busy_s, done_s;
  logic       tc_m, busy_m, done_m;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  contador_carga #(.W(4), .WRAP(1'b1), .MAXV(15)) dut_w (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .e_i    (e),
    .load_i (load),
    .data_i (data[3:0]),
`ifdef CONTADOR_UPDOWN_EN
    .up_i   (up),
`endif
    .q_o    (q_w),
    .tc_o   (tc_w),
    .busy_o (busy_w),
    .done_o (done_w)
  );

  contador_carga #(.W(4), .WRAP(1'b0), .MAXV(15)) dut_s (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .e_i    (e),
    .load_i (load),
    .data_i (data[3:0]),
`ifdef CONTADOR_UPDOWN_EN
    .up_i   (up),
`endif
    .q_o    (q_s),
    .tc_o   (tc_s),
    .busy_o (busy_s),
    .done_o (done_s)
  );

  contador_carga #(.W(5), .WRAP(1'b1), .MAXV(12)) dut_m (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .e_i    (e),
    .load_i (load),
    .data_i (data),
`ifdef CONTADOR_UPDOWN_EN
    .up_i   (up),
`endif
    .q_o    (q_m),
    .tc_o   (tc_m),
    .busy_o (busy_m),
    .done_o (done_m)
  );

  typedef struct {
    int unsigned which;
    logic [4:0]  q;
    logic        tc;
    logic        busy;
    logic        done;
  } exp_t;

  typedef struct {
    logic       ld;
    logic       en;
    logic [4:0] d;
    logic [4:0] q;
    logic       tc;
    logic       busy;
    logic       done;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[16];

  function automatic logic [7:0] pick(input int unsigned w);
    case (w)
      0:       return {1'b0, q_w, tc_w, busy_w, done_w};
      1:       return {1'b0, q_s, tc_s, busy_s, done_s};
      default: return {q_m, tc_m, busy_m, done_m};
    endcase
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got q=%0d tc=%b busy=%b done=%b, expected q=%0d tc=%b busy=%b done=%b",
               name, act[7:3], act[2], act[1], act[0], exp[7:3], exp[2], exp[1], exp[0]);
    end
  endtask

  // Drive one edge of stimulus; the expectation is queued with it and retired after the edge.
  task automatic drive(input string name, input int unsigned w, input logic ld, input logic en,
                       input logic [4:0] d, input logic [4:0] eq, input logic etc,
                       input logic eb, input logic ed);
    exp_t x;
    load = ld;
    e    = en;
    data = d;
    sb.push_back('{which: w, q: eq, tc: etc, busy: eb, done: ed});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      x = sb.pop_front();
      check(name, pick(x.which), {x.q, x.tc, x.busy, x.done});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    e     = 1'b0;
    load  = 1'b0;
    data  = '0;
`ifdef CONTADOR_UPDOWN_EN
    up    = 1'b1;
`endif

    vecs[0]  = '{1'b1, 1'b1, 5'd7,  5'd7,  1'b0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 5'd0,  5'd8,  1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 5'd0,  5'd9,  1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 5'd0,  5'd10, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 5'd14, 5'd14, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 5'd0,  5'd15, 1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 5'd0,  5'd1,  1'b0, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 5'd0,  5'd1,  1'b0, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 5'd0,  5'd1,  1'b0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 5'd0,  5'd2,  1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 5'd0,  5'd2,  1'b0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b0, 5'd15, 5'd15, 1'b0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 5'd0,  5'd1,  1'b0, 1'b1, 1'b0};

    // Reset state, all three instances.
    #12;
    for (int i = 0; i < 3; i++) check($sformatf("reset_%0d", i), pick(i), 8'h00);
    rst_n = 1'b1;

    // Wrapping counter, W=4, MAXV=15.
    for (int i = 0; i < 16; i++) begin
      drive($sformatf("vec_%0d", i), 0, vecs[i].ld, vecs[i].en, vecs[i].d,
            vecs[i].q, vecs[i].tc, vecs[i].busy, vecs[i].done);
    end

    // Stopping counter reaches DONE, ignores e, leaves only through load.
    drive("stop_load14", 1, 1'b1, 1'b0, 5'd14, 5'd14, 1'b0, 1'b0, 1'b0);
    drive("stop_e1",     1, 1'b0, 1'b1, 5'd0,  5'd15, 1'b0, 1'b1, 1'b0);
    drive("stop_e2",     1, 1'b0, 1'b1, 5'd0,  5'd15, 1'b1, 1'b0, 1'b1);
    drive("stop_e3",     1, 1'b0, 1'b1, 5'd0,  5'd15, 1'b0, 1'b0, 1'b1);
    drive("stop_e4",     1, 1'b0, 1'b0, 5'd0,  5'd15, 1'b0, 1'b0, 1'b1);
    drive("stop_load3",  1, 1'b1, 1'b1, 5'd3,  5'd3,  1'b0, 1'b0, 1'b0);
    drive("stop_after",  1, 1'b0, 1'b1, 5'd0,  5'd4,  1'b0, 1'b1, 1'b0);

    // W=5, MAXV=12: clamped loads and wrap at 12 rather than 31.
    drive("m_load20",   2, 1'b1, 1'b1, 5'd20, 5'd12, 1'b0, 1'b0, 1'b0);
    drive("m_wrap",     2, 1'b0, 1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0);
    drive("m_inc",      2, 1'b0, 1'b1, 5'd0,  5'd1,  1'b0, 1'b1, 1'b0);
    drive("m_load13",   2, 1'b1, 1'b0, 5'd13, 5'd12, 1'b0, 1'b0, 1'b0);
    drive("m_load11",   2, 1'b1, 1'b0, 5'd11, 5'd11, 1'b0, 1'b0, 1'b0);
    drive("m_to_max",   2, 1'b0, 1'b1, 5'd0,  5'd12, 1'b0, 1'b1, 1'b0);
    drive("m_wrap2",    2, 1'b0, 1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a count.
    drive("r_load5", 0, 1'b1, 1'b0, 5'd5, 5'd5, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      drive($sformatf("r_cnt_%0d", i), 0, 1'b0, 1'b1, 5'd0, 5'(6 + i), 1'b0, 1'b1, 1'b0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", pick(0), 8'h00);
    @(posedge clk);
    #1;
    check("reset_held", pick(0), 8'h00);
    rst_n = 1'b1;
    drive("after_reset", 0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);

`ifdef CONTADOR_UPDOWN_EN
    up = 1'b0;
    drive("dn_load1", 0, 1'b1, 1'b0, 5'd1, 5'd1,  1'b0, 1'b0, 1'b0);
    drive("dn_0",     0, 1'b0, 1'b1, 5'd0, 5'd0,  1'b0, 1'b1, 1'b0);
    drive("dn_wrap",  0, 1'b0, 1'b1, 5'd0, 5'd15, 1'b1, 1'b1, 1'b0);
    drive("dn_14",    0, 1'b0, 1'b1, 5'd0, 5'd14, 1'b0, 1'b1, 1'b0);
    drive("dns_load", 1, 1'b1, 1'b0, 5'd1, 5'd1,  1'b0, 1'b0, 1'b0);
    drive("dns_0",    1, 1'b0, 1'b1, 5'd0, 5'd0,  1'b0, 1'b1, 1'b0);
    drive("dns_done", 1, 1'b0, 1'b1, 5'd0, 5'd0,  1'b1, 1'b0, 1'b1);
    up = 1'b1;
    drive("dns_hold", 1, 1'b0, 1'b1, 5'd0, 5'd0,  1'b0, 1'b0, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
